stopwatch_lap: RTL and testbench

//  Parametrised stopwatch, successor to the fixed cs/sec/min timer.
//  - Prescaled centisecond tick; start/stop toggle; clear; sticky overflow.
//  - Lap capture into a small show-ahead FIFO.
//  - Everything on one clock edge.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/stopwatch_lap_mod_counter.sv | 37 +++
 rtl/stopwatch_lap.sv | 159 +++++++++++++++
 tb/tb_stopwatch_lap.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Purpose  : Shared moduli, widths and width helpers for the lap stopwatch
//  Revision : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    localparam int CSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int CSEC_W   = 7;
    localparam int SEC_W    = 6;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Minute counter width for a given minute modulus.
    function automatic int min_w(input int min_max);
        return width_for(min_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_lap_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo-MOD up-counter with synchronous clear and carry-out,
//             chained carry->inc to build the time-of-day digits
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         res,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Carry is combinational so the next digit advances on the same edge.
    assign carry = inc & (q == LAST);

    // Count with wrap at MOD-1; the value never leaves 0..MOD-1.
    always_ff @(posedge clk) begin
        if (!res) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == LAST) ? '0 : q + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_lap
//  Purpose  : Parametrised centisecond stopwatch with sticky overflow and a
//             show-ahead lap-capture FIFO
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV   = 100,
    parameter int MIN_MAX   = 60,
    parameter int LAP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       start_stop,
    input  logic                       clr,
    input  logic                       lap,
    input  logic                       lap_rd,
    output logic                       run,
    output logic [CSEC_W-1:0]          csec,
    output logic [SEC_W-1:0]           sec,
    output logic [min_w(MIN_MAX)-1:0]  min,
    output logic                       ovf,
    output logic                       lap_valid,
    output logic                       lap_full,
    output logic                       lap_ovf,
    output logic [CSEC_W-1:0]          lap_csec,
    output logic [SEC_W-1:0]           lap_sec,
    output logic [min_w(MIN_MAX)-1:0]  lap_min
);

    localparam int                 MIN_W    = min_w(MIN_MAX);
    localparam int                 PRE_W    = width_for(CLK_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam int                 AW       = $clog2(LAP_DEPTH);
    localparam int                 ENT_W    = MIN_W + SEC_W + CSEC_W;

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             clr_go;
    logic             csec_carry;
    logic             sec_carry;
    logic             min_carry;

    logic [ENT_W-1:0] mem [LAP_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    // Clear is only honoured while stopped, so it can never race a tick.
    assign clr_go = clr & ~run;
    assign tick   = run & (pre == PRE_LAST);

    // Run flag toggles on every start_stop pulse.
    always_ff @(posedge clk) begin
        if (!res) begin
            run <= 1'b0;
        end else if (start_stop) begin
            run <= ~run;
        end
    end

    // Prescaler advances only while running, so a resume keeps its phase.
    always_ff @(posedge clk) begin
        if (!res) begin
            pre <= '0;
        end else if (clr_go) begin
            pre <= '0;
        end else if (run) begin
            pre <= tick ? '0 : pre + PRE_W'(1);
        end
    end

    mod_counter #(.MOD(CSEC_MOD), .W(CSEC_W)) u_csec (
        .clk   (clk),
        .res   (res),
        .clr   (clr_go),
        .inc   (tick),
        .q     (csec),
        .carry (csec_carry)
    );

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk   (clk),
        .res   (res),
        .clr   (clr_go),
        .inc   (csec_carry),
        .q     (sec),
        .carry (sec_carry)
    );

    mod_counter #(.MOD(MIN_MAX), .W(MIN_W)) u_min (
        .clk   (clk),
        .res   (res),
        .clr   (clr_go),
        .inc   (sec_carry),
        .q     (min),
        .carry (min_carry)
    );

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = lap_rd & ~empty;
    // A read in the same cycle frees the slot being written, so push is allowed.
    assign push  = lap & (~full | lap_rd);
    assign drop  = lap & full & ~lap_rd;

    // Sticky flags: clear first so a same-cycle set event still wins.
    always_ff @(posedge clk) begin
        if (!res) begin
            ovf     <= 1'b0;
            lap_ovf <= 1'b0;
        end else begin
            if (clr_go) begin
                ovf     <= 1'b0;
                lap_ovf <= 1'b0;
            end
            if (min_carry) begin
                ovf <= 1'b1;
            end
            if (drop) begin
                lap_ovf <= 1'b1;
            end
        end
    end

    // Lap FIFO storage and pointers; captures the pre-edge time value.
    always_ff @(posedge clk) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {min, sec, csec};
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign lap_valid                    = ~empty;
    assign lap_full                     = full;
    assign {lap_min, lap_sec, lap_csec} = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_lap
//  Purpose  : Self-checking bench for stopwatch_lap (CLK_DIV=2, MIN_MAX=3,
//             LAP_DEPTH=4): vector table, directed corners, random vs model
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_lap;

    localparam int CLK_DIV   = 2;
    localparam int MIN_MAX   = 3;
    localparam int LAP_DEPTH = 4;
    localparam int MIN_W     = 2;
    localparam int HW        = MIN_W + 13;
    localparam int T_MOD     = 100 * 60 * MIN_MAX;

    logic             clk = 1'b0;
    logic             res, start_stop, clr, lap, lap_rd;
    logic             run, ovf, lap_valid, lap_full, lap_ovf;
    logic [6:0]       csec, lap_csec;
    logic [5:0]       sec, lap_sec;
    logic [MIN_W-1:0] min, lap_min;

    stopwatch_lap #(
        .CLK_DIV   (CLK_DIV),
        .MIN_MAX   (MIN_MAX),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start_stop (start_stop),
        .clr        (clr),
        .lap        (lap),
        .lap_rd     (lap_rd),
        .run        (run),
        .csec       (csec),
        .sec        (sec),
        .min        (min),
        .ovf        (ovf),
        .lap_valid  (lap_valid),
        .lap_full   (lap_full),
        .lap_ovf    (lap_ovf),
        .lap_csec   (lap_csec),
        .lap_sec    (lap_sec),
        .lap_min    (lap_min)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: elapsed time as one integer of centiseconds.
    bit  m_run, m_ovf, m_lovf;
    int  m_pre, m_t;
    int  m_q[$];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        bit r, ss, c, l, lr;
        bit run;
        int csec;
        bit lv;
        int hc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] dut_bundle();
        logic [HW-1:0] hd;
        hd = lap_valid ? {lap_min, lap_sec, lap_csec} : '0;
        return 64'({run, ovf, lap_valid, lap_full, lap_ovf, min, sec, csec, hd});
    endfunction

    function automatic logic [63:0] model_bundle();
        logic [HW-1:0] hd;
        int h;
        bit lv, lf;
        lv = (m_q.size() > 0);
        lf = (m_q.size() == LAP_DEPTH);
        hd = '0;
        if (lv) begin
            h  = m_q[0];
            hd = {MIN_W'(h / 6000), 6'((h / 100) % 60), 7'(h % 100)};
        end
        return 64'({m_run, m_ovf, lv, lf, m_lovf,
                    MIN_W'(m_t / 6000), 6'((m_t / 100) % 60), 7'(m_t % 100), hd});
    endfunction

    task automatic model_update(input bit r, input bit ss, input bit c, input bit l, input bit lr);
        int cap;
        int n;
        bit tk;
        if (!r) begin
            m_run = 0; m_pre = 0; m_t = 0; m_ovf = 0; m_lovf = 0;
            m_q.delete();
            return;
        end
        cap = m_t;
        n   = m_q.size();
        tk  = m_run && (m_pre == CLK_DIV - 1);
        if (c && !m_run) begin
            m_t = 0; m_pre = 0; m_ovf = 0; m_lovf = 0;
        end else if (m_run) begin
            if (tk) begin
                m_pre = 0;
                m_t++;
                if (m_t == T_MOD) begin
                    m_t   = 0;
                    m_ovf = 1;
                end
            end else begin
                m_pre++;
            end
        end
        if (ss) m_run = ~m_run;
        if (lr && n > 0) void'(m_q.pop_front());
        if (l && (n < LAP_DEPTH || lr)) m_q.push_back(cap);
        else if (l) m_lovf = 1;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input bit r, input bit ss, input bit c, input bit l, input bit lr);
        res = r; start_stop = ss; clr = c; lap = l; lap_rd = lr;
        @(posedge clk);
        model_update(r, ss, c, l, lr);
        #1;
        chk("model", dut_bundle(), model_bundle());
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        int cap[5];
        int max_csec;
        res = 0; start_stop = 0; clr = 0; lap = 0; lap_rd = 0;

        //            r  ss c  l  lr  run csec lv hc
        vecs[0]  = '{1, 1, 0, 0, 0,  1,  0,  0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,  1,  0,  0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0,  1,  1,  0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0,  1,  1,  1, 1};
        vecs[4]  = '{1, 0, 0, 1, 0,  1,  2,  1, 1};
        vecs[5]  = '{1, 0, 0, 0, 1,  1,  2,  1, 1};
        vecs[6]  = '{1, 0, 0, 0, 1,  1,  3,  0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0,  0,  3,  0, 0};
        vecs[8]  = '{1, 0, 1, 0, 0,  0,  0,  0, 0};
        vecs[9]  = '{1, 1, 1, 0, 0,  1,  0,  0, 0};
        vecs[10] = '{1, 0, 0, 0, 0,  1,  0,  0, 0};
        vecs[11] = '{1, 0, 1, 0, 0,  1,  1,  0, 0};
        vecs[12] = '{0, 1, 0, 1, 0,  0,  0,  0, 0};

        // Reset held three cycles, then quiet: everything stays zero.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("quiet_zero", dut_bundle(), 64'd0);
        end

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            logic [63:0] act, exp;
            step(vecs[i].r, vecs[i].ss, vecs[i].c, vecs[i].l, vecs[i].lr);
            act = 64'({run, lap_valid, csec, (lap_valid ? lap_csec : 7'd0), sec, min});
            exp = 64'({vecs[i].run, vecs[i].lv, 7'(vecs[i].csec), 7'(vecs[i].hc), 6'd0, MIN_W'(0)});
            chk($sformatf("vec%0d", i), act, exp);
        end

        // 200 cycles after run rises: 99 -> 1.00, never above 99.
        step(1, 1, 0, 0, 0);
        max_csec = 0;
        for (int i = 0; i < 199; i++) begin
            idle();
            if (int'(csec) > max_csec) max_csec = int'(csec);
        end
        chk("cyc199_time", 64'({sec, csec}), 64'({6'd0, 7'd99}));
        idle();
        chk("cyc200_time", 64'({sec, csec}), 64'({6'd1, 7'd0}));
        chk("csec_max", 64'(max_csec), 64'd99);

        // Run to 2:59.99 then wrap minutes.
        for (int k = 0; k < 40000 && m_t != T_MOD - 1; k++) idle();
        chk("at_2_59_99", 64'({min, sec, csec, ovf}), 64'({2'd2, 6'd59, 7'd99, 1'b0}));
        for (int k = 0; k < 4 && m_t == T_MOD - 1; k++) idle();
        chk("wrap_zero_ovf", 64'({min, sec, csec, ovf}), 64'({2'd0, 6'd0, 7'd0, 1'b1}));
        for (int i = 0; i < 10; i++) idle();
        chk("ovf_holds", 64'({run, ovf}), 64'(2'b11));
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("stop_clr", 64'({run, ovf, min, sec, csec}), 64'd0);

        // Two laps, then pop them in order.
        step(1, 1, 0, 0, 0);
        for (int k = 0; k < 50 && m_t != 5; k++) idle();
        step(1, 0, 0, 1, 0);
        for (int k = 0; k < 50 && m_t != 17; k++) idle();
        step(1, 0, 0, 1, 0);
        idle();
        chk("lap_head5", 64'({lap_valid, lap_csec}), 64'({1'b1, 7'd5}));
        step(1, 0, 0, 0, 1);
        chk("lap_head17", 64'({lap_valid, lap_csec}), 64'({1'b1, 7'd17}));
        step(1, 0, 0, 0, 1);
        chk("lap_empty", 64'(lap_valid), 64'd0);

        // Five laps into a four-deep FIFO.
        for (int i = 0; i < 5; i++) begin
            cap[i] = m_t;
            step(1, 0, 0, 1, 0);
            if (i == 3) chk("full_after4", 64'({lap_full, lap_ovf}), 64'(2'b10));
            if (i == 4) chk("ovf_after5", 64'({lap_full, lap_ovf, lap_csec}),
                            64'({1'b1, 1'b1, 7'(cap[0] % 100)}));
            idle();
        end
        step(1, 0, 0, 1, 1);
        chk("full_push_pop", 64'({lap_full, lap_csec}), 64'({1'b1, 7'(cap[1] % 100)}));
        for (int j = 0; j < 4; j++) begin
            step(1, 0, 0, 0, 1);
            if (j == 2) chk("three_popped", 64'(lap_valid), 64'd1);
            if (j == 3) chk("four_popped", 64'(lap_valid), 64'd0);
        end

        // clr while running is ignored; reset mid-count zeroes everything.
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        chk("clr_running", 64'({run, lap_valid, (|{min, sec, csec})}), 64'(3'b111));
        step(0, 0, 0, 0, 0);
        chk("mid_reset", dut_bundle(), 64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                 $urandom_range(3) == 0, $urandom_range(3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
